// File: rtl/game_referee.sv
// Tic-tac-toe style referee for an N x N board.
// Validates moves, tracks the board and turn, and reports win/lose/draw.
module game_referee #(
  parameter  int N     = 3,
  localparam int CELLS = N * N,
  localparam int IW    = $clog2(CELLS),
  localparam int CW    = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_game,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic             move_player,
  input  logic [IW-1:0]    move_idx,
  output logic [CELLS-1:0] xin_star,
  output logic [CELLS-1:0] oin_star,
  output logic             turn,
  output logic [CW-1:0]    move_count,
  output logic             win_game,
  output logic             lose_game,
  output logic             draw_game,
  output logic             bad_move,
  output logic             playing_game
);

  localparam int NL = 2 * N + 2;
  localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};
  localparam logic [IW:0]      LIM = CELLS[IW:0];
  localparam logic [CW-1:0]    FULL = CELLS[CW-1:0];

  // All row, column and diagonal masks, packed one mask per CELLS-bit slot.
  function automatic logic [NL*CELLS-1:0] build_masks();
    logic [NL*CELLS-1:0] f;
    logic [CELLS-1:0]    r, c, d, a;
    f = '0;
    d = '0;
    a = '0;
    for (int i = 0; i < N; i++) begin
      r = '0;
      c = '0;
      for (int j = 0; j < N; j++) begin
        r = r | (ONE << (i * N + j));
        c = c | (ONE << (j * N + i));
      end
      f = f | ({{((NL-1)*CELLS){1'b0}}, r} << (i * CELLS));
      f = f | ({{((NL-1)*CELLS){1'b0}}, c} << ((N + i) * CELLS));
      d = d | (ONE << (i * N + i));
      a = a | (ONE << (i * N + N - 1 - i));
    end
    f = f | ({{((NL-1)*CELLS){1'b0}}, d} << (2 * N * CELLS));
    f = f | ({{((NL-1)*CELLS){1'b0}}, a} << ((2 * N + 1) * CELLS));
    return f;
  endfunction

  localparam logic [NL*CELLS-1:0] MASKS = build_masks();

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    OVER
  } state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_x;
  logic [CELLS-1:0] r_o;
  logic             r_turn;
  logic [CW-1:0]    r_cnt;
  logic             r_win;
  logic             r_lose;
  logic             r_draw;
  logic             r_bad;

  logic [NL-1:0]    w_xl;
  logic [NL-1:0]    w_ol;
  logic             w_xwin;
  logic             w_owin;
  logic [CELLS-1:0] w_cell;
  logic             w_oob;
  logic             w_occ;
  logic             w_legal;

  for (genvar k = 0; k < NL; k++) begin : g_line
    assign w_xl[k] = (r_x & MASKS[k*CELLS +: CELLS]) == MASKS[k*CELLS +: CELLS];
    assign w_ol[k] = (r_o & MASKS[k*CELLS +: CELLS]) == MASKS[k*CELLS +: CELLS];
  end

  assign w_xwin  = |w_xl;
  assign w_owin  = |w_ol;
  // Out-of-range indices shift the one-hot off the top, giving an empty cell mask.
  assign w_cell  = ONE << move_idx;
  assign w_oob   = {1'b0, move_idx} >= LIM;
  assign w_occ   = |((r_x | r_o) & w_cell);
  assign w_legal = !w_oob && !w_occ && (move_player == r_turn);

  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      r_state <= PLAY;
      r_x     <= '0;
      r_o     <= '0;
      r_turn  <= 1'b0;
      r_cnt   <= '0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_draw  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      unique case (r_state)
        PLAY: begin
          if (move_valid) begin
            if (w_legal) begin
              if (move_player) r_o <= r_o | w_cell;
              else             r_x <= r_x | w_cell;
              r_cnt   <= r_cnt + CW'(1);
              r_state <= CHECK;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        CHECK: begin
          // X is checked first; only the mover can have completed a line.
          if (w_xwin) begin
            r_win   <= 1'b1;
            r_state <= OVER;
          end else if (w_owin) begin
            r_lose  <= 1'b1;
            r_state <= OVER;
          end else if (r_cnt == FULL) begin
            r_draw  <= 1'b1;
            r_state <= OVER;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= PLAY;
          end
        end
        OVER: begin
          r_state <= OVER;
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  assign move_ready   = (r_state == PLAY);
  assign xin_star     = r_x;
  assign oin_star     = r_o;
  assign turn         = r_turn;
  assign move_count   = r_cnt;
  assign win_game     = r_win;
  assign lose_game    = r_lose;
  assign draw_game    = r_draw;
  assign bad_move     = r_bad;
  assign playing_game = ~(r_win | r_lose | r_draw);

endmodule
